multicycle_control_unit: RTL and testbench

Multicycle RISC-V main controller: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port. Supports R-type, I-type ALU, LW, SW, BEQ and JAL. Handles a variable-latency memory through a req/ready handshake, traps illegal opcodes, and optionally keeps cycle and retired-instruction counters. It drives the datapath mux selects, the register-file, IR and PC enables, and the memory port.

---
 rtl/mcu_pkg.sv | 58 +++++
 rtl/mcu_perf_counters.sv | 26 ++
 rtl/multicycle_control_unit.sv | 169 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared definitions for the multicycle RISC-V main controller: FSM states,
// opcodes and the datapath select / ALU-op encodings.
package mcu_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
    case (opcode)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mcu_perf_counters.sv
// Free-running cycle and retired-instruction counters for the controller;
// both wrap silently.
module mcu_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (active) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V main controller (Moore FSM). Define MCU_PERF_CNT_EN to
// build the cycle / retired-instruction counters; otherwise they read 0.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MEM_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_src,
  output logic [1:0]       result_src,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t state_q, state_d;
  logic   started_q;
  logic   ready_eff;
  logic   pc_update;
  logic   branch;

  assign ready_eff = (MEM_WAIT != 0) ? mem_ready : 1'b1;

  // started_q holds IDLE for exactly one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
    end
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    result_src = RES_ALUOUT;
    reg_write  = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_IDLE: if (started_q) state_d = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (ready_eff) begin
          ir_write  = 1'b1;
          pc_update = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (ready_eff) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (ready_eff) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_TRAP: illegal = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign pc_write = pc_update | (branch & zero);
  assign imm_src  = imm_src_of(opcode);

`ifdef MCU_PERF_CNT_EN
  logic active;
  logic retire;

  // A cycle counts when the edge ending it lands outside IDLE, so the
  // IDLE->FETCH edge is the first one counted.
  assign active = (state_d != S_IDLE);
  assign retire = (state_d == S_FETCH) &&
                  (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ});

  mcu_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (active),
    .retire    (retire),
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
  );
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: a driver walks directed state
// sequences and queues expected outputs; a negedge monitor pops and compares.
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  typedef enum {
    T_IDLE, T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
    T_EXECR, T_EXECI, T_ALUWB, T_BEQ, T_JAL, T_TRAP
  } tst_t;

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0] a, b, op, imm, res;
  } ctl_t;

  typedef struct {
    tst_t        st;
    ctl_t        ctl;
    logic [31:0] cyc;
    logic [31:0] ins;
    bit          chk2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = OP_BAD;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;

  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, imm_src, result_src;
  logic [31:0] cycle_cnt, instr_cnt;

  logic        mem_req2, mem_write2, adr_src2, ir_write2, pc_write2, reg_write2, illegal2;
  logic [1:0]  alu_src_a2, alu_src_b2, alu_op2, imm_src2, result_src2;
  logic [31:0] cycle_cnt2, instr_cnt2;

  ctl_t act1, act2;
  assign act1 = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal,
                 alu_src_a, alu_src_b, alu_op, imm_src, result_src};
  assign act2 = {mem_req2, mem_write2, adr_src2, ir_write2, pc_write2, reg_write2, illegal2,
                 alu_src_a2, alu_src_b2, alu_op2, imm_src2, result_src2};

  always #5 clk = ~clk;

  multicycle_control_unit #(.CNT_W(32), .MEM_WAIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .result_src(result_src), .reg_write(reg_write), .illegal(illegal),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  // Same stimulus, but MEM_WAIT=0 with mem_ready stuck low.
  multicycle_control_unit #(.CNT_W(32), .MEM_WAIT(0)) dut_nowait (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(1'b0),
    .mem_req(mem_req2), .mem_write(mem_write2), .adr_src(adr_src2), .ir_write(ir_write2),
    .pc_write(pc_write2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_op(alu_op2),
    .imm_src(imm_src2), .result_src(result_src2), .reg_write(reg_write2), .illegal(illegal2),
    .cycle_cnt(cycle_cnt2), .instr_cnt(instr_cnt2)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  exp_t        q[$];
  logic [31:0] exp_cyc = '0;
  logic [31:0] exp_ins = '0;
  tst_t        prev = T_IDLE;
  bit          chk2_phase = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ctl_t model(tst_t s, logic rdy, logic z, logic [6:0] opc);
    ctl_t c = '0;
    case (opc)
      OP_SW:   c.imm = 2'b01;
      OP_BEQ:  c.imm = 2'b10;
      OP_JAL:  c.imm = 2'b11;
      default: c.imm = 2'b00;
    endcase
    case (s)
      T_FETCH:    begin c.mem_req = 1; c.b = 2'b10; c.res = 2'b10;
                        c.ir_write = rdy; c.pc_write = rdy; end
      T_DECODE:   begin c.a = 2'b01; c.b = 2'b01; end
      T_MEMADR:   begin c.a = 2'b10; c.b = 2'b01; end
      T_MEMREAD:  begin c.mem_req = 1; c.adr_src = 1; end
      T_MEMWB:    begin c.res = 2'b01; c.reg_write = 1; end
      T_MEMWRITE: begin c.mem_req = 1; c.mem_write = 1; c.adr_src = 1; end
      T_EXECR:    begin c.a = 2'b10; c.b = 2'b00; c.op = 2'b10; end
      T_EXECI:    begin c.a = 2'b10; c.b = 2'b01; c.op = 2'b10; end
      T_ALUWB:    begin c.reg_write = 1; end
      T_BEQ:      begin c.a = 2'b10; c.op = 2'b01; c.pc_write = z; end
      T_JAL:      begin c.a = 2'b01; c.b = 2'b10; c.pc_write = 1; end
      T_TRAP:     begin c.illegal = 1; end
      default:    ;
    endcase
    return c;
  endfunction

  // One clock cycle: the DUT is expected to be in state s after this edge.
  task automatic cyc(input tst_t s, input logic [6:0] opc,
                     input logic rdy = 1'b1, input logic z = 1'b0);
    exp_t e;
    @(posedge clk); #1;
    opcode = opc; mem_ready = rdy; zero = z;
    if (s != T_IDLE) exp_cyc++;
    if (s == T_FETCH && prev inside {T_MEMWB, T_MEMWRITE, T_ALUWB, T_BEQ}) exp_ins++;
    prev   = s;
    e.st   = s;
    e.ctl  = model(s, rdy, z, opc);
    e.cyc  = exp_cyc;
    e.ins  = exp_ins;
    e.chk2 = chk2_phase;
    q.push_back(e);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear at once.
  task automatic do_reset(input bit in_memwrite);
    @(posedge clk); #2;
    if (in_memwrite) begin
      check("pre-reset mem_req", mem_req, 1'b1);
      check("pre-reset mem_write", mem_write, 1'b1);
    end
    #1; rst_n = 1'b0; opcode = OP_BAD; zero = 1'b0;
    #1;
    check("reset ctl", act1, '0);
    check("reset cycle_cnt", cycle_cnt, '0);
    check("reset instr_cnt", instr_cnt, '0);
    check("reset ctl nowait", act2, '0);
    exp_cyc = '0; exp_ins = '0; prev = T_IDLE;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    logic [31:0] ec, ei;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
`ifdef MCU_PERF_CNT_EN
        ec = e.cyc; ei = e.ins;
`else
        ec = '0; ei = '0;
`endif
        check($sformatf("%s ctl", e.st.name()), act1, e.ctl);
        check($sformatf("%s cycle_cnt", e.st.name()), cycle_cnt, ec);
        check($sformatf("%s instr_cnt", e.st.name()), instr_cnt, ei);
        if (e.chk2) begin
          check($sformatf("%s ctl nowait", e.st.name()), act2, e.ctl);
          check($sformatf("%s cycle_cnt nowait", e.st.name()), cycle_cnt2, ec);
        end
      end
    end
  end

  initial begin : driver
    do_reset(1'b0);
    cyc(T_IDLE, OP_BAD);

    // Both instances in lockstep: mem_ready=1 here, the no-wait copy sees 0.
    chk2_phase = 1'b1;
    cyc(T_FETCH, OP_R); cyc(T_DECODE, OP_R); cyc(T_EXECR, OP_R); cyc(T_ALUWB, OP_R);
    cyc(T_FETCH, OP_SW); cyc(T_DECODE, OP_SW); cyc(T_MEMADR, OP_SW); cyc(T_MEMWRITE, OP_SW);
    cyc(T_FETCH, OP_BEQ); cyc(T_DECODE, OP_BEQ); cyc(T_BEQ, OP_BEQ, 1'b1, 1'b1);
    cyc(T_FETCH, OP_BEQ); cyc(T_DECODE, OP_BEQ); cyc(T_BEQ, OP_BEQ, 1'b1, 1'b0);
    cyc(T_FETCH, OP_JAL); cyc(T_DECODE, OP_JAL); cyc(T_JAL, OP_JAL); cyc(T_ALUWB, OP_JAL);
    cyc(T_FETCH, OP_I); cyc(T_DECODE, OP_I); cyc(T_EXECI, OP_I); cyc(T_ALUWB, OP_I);
    cyc(T_FETCH, OP_LW); cyc(T_DECODE, OP_LW); cyc(T_MEMADR, OP_LW);
    cyc(T_MEMREAD, OP_LW); cyc(T_MEMWB, OP_LW);
    chk2_phase = 1'b0;

    // Variable-latency memory: LW with 3 wait cycles, fetch wait, write wait.
    cyc(T_FETCH, OP_LW); cyc(T_DECODE, OP_LW); cyc(T_MEMADR, OP_LW, 1'b0);
    for (int i = 0; i < 3; i++) cyc(T_MEMREAD, OP_LW, 1'b0);
    cyc(T_MEMREAD, OP_LW); cyc(T_MEMWB, OP_LW, 1'b0);
    cyc(T_FETCH, OP_I, 1'b0); cyc(T_FETCH, OP_I); cyc(T_DECODE, OP_I, 1'b0);
    cyc(T_EXECI, OP_I); cyc(T_ALUWB, OP_I);
    cyc(T_FETCH, OP_SW); cyc(T_DECODE, OP_SW); cyc(T_MEMADR, OP_SW);
    cyc(T_MEMWRITE, OP_SW, 1'b0); cyc(T_MEMWRITE, OP_SW);

    // Illegal opcode: sticky TRAP, cycle counter keeps running.
    cyc(T_FETCH, OP_BAD); cyc(T_DECODE, OP_BAD);
    for (int i = 0; i < 4; i++) cyc(T_TRAP, OP_BAD, i[0]);
    do_reset(1'b0);
    cyc(T_IDLE, OP_BAD);

    // Reset while MEMWRITE waits on the memory, then restart cleanly.
    cyc(T_FETCH, OP_SW); cyc(T_DECODE, OP_SW); cyc(T_MEMADR, OP_SW);
    cyc(T_MEMWRITE, OP_SW, 1'b0); cyc(T_MEMWRITE, OP_SW, 1'b0);
    do_reset(1'b1);
    cyc(T_IDLE, OP_BAD);
    cyc(T_FETCH, OP_R); cyc(T_DECODE, OP_R); cyc(T_EXECR, OP_R); cyc(T_ALUWB, OP_R);
    cyc(T_FETCH, OP_BEQ);

    repeat (3) @(negedge clk);
    check("scoreboard drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
